// File: rtl/hwpe_ctrl_periph_rf_bridge.sv
// Periph-bus target in front of the controller register file.
// Adds a small control space (trigger/status/job-id/clear) and a job FSM.
module hwpe_ctrl_periph_rf_bridge #(
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned IdWidth   = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic [AddrWidth+2:0]   add_i,
   input  logic                   wen_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [DataWidth-1:0]   data_i,
   input  logic [IdWidth-1:0]     id_i,
   output logic [DataWidth-1:0]   r_data_o,
   output logic                   r_valid_o,
   output logic [IdWidth-1:0]     r_id_o,
   output logic                   rf_re_o,
   output logic [AddrWidth-1:0]   rf_raddr_o,
   input  logic [DataWidth-1:0]   rf_rdata_i,
   output logic                   rf_we_o,
   output logic [AddrWidth-1:0]   rf_waddr_o,
   output logic [DataWidth-1:0]   rf_wdata_o,
   output logic [DataWidth/8-1:0] rf_wbe_o,
   output logic                   rf_clear_o,
   output logic                   start_o,
   input  logic                   busy_i,
   input  logic                   done_i,
   output logic                   evt_o,
   output logic [IdWidth-1:0]     job_id_o
);

   localparam logic [0:0] StIdle    = 1'b0;
   localparam logic [0:0] StRunning = 1'b1;

   localparam logic [1:0] OffTrigger = 2'd0;
   localparam logic [1:0] OffStatus  = 2'd1;
   localparam logic [1:0] OffJobId   = 2'd2;
   localparam logic [1:0] OffClear   = 2'd3;

   logic [0:0]           state_q, state_d;
   logic [IdWidth-1:0]   job_id_q, job_id_d;
   logic                 r_valid_q, r_valid_d;
   logic [IdWidth-1:0]   r_id_q, r_id_d;
   logic [DataWidth-1:0] r_data_q, r_data_d;

   logic       is_ctrl;
   logic       is_wr;
   logic [1:0] off;
   logic       running;
   logic       stall;
   logic       gnt;
   logic       trigger;
   logic       soft_clear;
   logic       unused_addr;

   assign is_ctrl = add_i[AddrWidth+2];
   assign is_wr   = ~wen_i;
   assign off     = add_i[3:2];
   assign running = (state_q == StRunning);

   // byte-offset bits never select anything
   assign unused_addr = ^add_i[1:0];

   // writes that would disturb a running job wait for it to finish
   assign stall = running & is_wr
                & (~is_ctrl | (off == OffTrigger));
   assign gnt   = req_i & ~stall;
   assign gnt_o = gnt;

   assign trigger    = gnt & is_wr & is_ctrl
                     & (off == OffTrigger);
   assign soft_clear = gnt & is_wr & is_ctrl
                     & (off == OffClear);

   assign rf_re_o    = gnt & wen_i & ~is_ctrl;
   assign rf_raddr_o = add_i[AddrWidth+1:2];
   assign rf_we_o    = gnt & is_wr & ~is_ctrl;
   assign rf_waddr_o = add_i[AddrWidth+1:2];
   assign rf_wdata_o = data_i;
   assign rf_wbe_o   = be_i;
   assign rf_clear_o = soft_clear;

   assign start_o = trigger;
   assign evt_o   = running & done_i & ~soft_clear;

   assign r_valid_o = r_valid_q;
   assign r_id_o    = r_id_q;
   assign r_data_o  = r_data_q;
   assign job_id_o  = job_id_q;

   // job FSM: soft clear wins over trigger and done
   always_comb begin
      state_d  = state_q;
      job_id_d = job_id_q;
      if (soft_clear) begin
         state_d = StIdle;
      end else if (trigger) begin
         state_d  = StRunning;
         job_id_d = job_id_q + IdWidth'(1);
      end else if (running && done_i) begin
         state_d = StIdle;
      end
   end

   // response path: every grant answers one cycle later
   always_comb begin
      r_valid_d = gnt;
      r_id_d    = gnt ? id_i : '0;
      r_data_d  = '0;
      if (gnt && wen_i) begin
         if (!is_ctrl) begin
            r_data_d = rf_rdata_i;
         end else begin
            case (off)
               OffStatus: r_data_d[1:0] = {busy_i, running};
               OffJobId:  r_data_d = DataWidth'(job_id_q);
               default:   r_data_d = '0;
            endcase
         end
      end
   end

   // state and response registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         job_id_q  <= '0;
         r_valid_q <= 1'b0;
         r_id_q    <= '0;
         r_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         job_id_q  <= job_id_d;
         r_valid_q <= r_valid_d;
         r_id_q    <= r_id_d;
         r_data_q  <= r_data_d;
      end
   end

endmodule

// File: doc/hwpe_ctrl_periph_rf_bridge.md
Name: hwpe_ctrl_periph_rf_bridge

Overview:
Peripheral-bus target that sits directly upstream of the controller register file. It turns PULP-style periph requests into register-file read/write port accesses and adds a small control space. The control space holds trigger, status, job-ID and soft-clear registers. A job FSM blocks register-file writes while the engine is running.

Parameters:
AddrWidth, 5, register-file word-address width (register file holds 2**AddrWidth words)
DataWidth, 32, data width; must be a multiple of 8
IdWidth, 8, periph transaction ID width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_i  in  1  periph request
gnt_o  out  1  periph grant (combinational)
add_i  in  AddrWidth+3  byte address; bit [AddrWidth+2] 0=register file, 1=control space; bits [1:0] ignored
wen_i  in  1  0=write, 1=read
be_i  in  DataWidth/8  byte enables
data_i  in  DataWidth  write data
id_i  in  IdWidth  transaction ID
r_data_o  out  DataWidth  read response data
r_valid_o  out  1  response valid
r_id_o  out  IdWidth  response ID
rf_re_o  out  1  register-file read enable
rf_raddr_o  out  AddrWidth  register-file read address
rf_rdata_i  in  DataWidth  register-file read data (combinational, same cycle)
rf_we_o  out  1  register-file write enable
rf_waddr_o  out  AddrWidth  register-file write address
rf_wdata_o  out  DataWidth  register-file write data
rf_wbe_o  out  DataWidth/8  register-file byte enables
rf_clear_o  out  1  register-file clear pulse
start_o  out  1  engine start pulse
busy_i  in  1  engine busy (status only)
done_i  in  1  engine done pulse
evt_o  out  1  job-end event pulse
job_id_o  out  IdWidth  ID of the last triggered job

Behaviour:
- Reset: FSM=IDLE; r_valid_o, r_data_o, r_id_o, start_o, evt_o, job_id_o all 0.
- FSM states:
  - IDLE: a granted write to TRIGGER (control offset 0x0) -> RUNNING. The same cycle drives start_o=1 and job_id_o+1, wrapping at 2**IdWidth.
  - RUNNING: done_i=1 -> IDLE, with evt_o=1 for one cycle. done_i is ignored in IDLE.
- Grant rules:
  - gnt_o = req_i, except writes to the register file or to TRIGGER while RUNNING, which get gnt_o=0 until the FSM returns to IDLE.
  - Reads are always granted.
- Register-file write (granted, addr bit=0, wen_i=0): rf_we_o=1 in the same cycle. rf_waddr_o=add_i[AddrWidth+1:2]; data_i and be_i pass through.
- Register-file read (granted, wen_i=1): rf_re_o=1 with address add_i[AddrWidth+1:2]. rf_rdata_i is registered into r_data_o.
- Response timing: every granted request produces r_valid_o=1 exactly one cycle later, with r_id_o=id_i. For writes, r_data_o=0. Back-to-back grants give back-to-back responses.
- Control space (offset = add_i[3:2]):
  - 0x0 TRIGGER: write only; reads return 0.
  - 0x4 STATUS: read = {zeros, busy_i, state==RUNNING}; writes ignored.
  - 0x8 JOB_ID: read = job_id_o zero-extended; writes ignored.
  - 0xC SOFT_CLEAR: a write is always granted, pulses rf_clear_o in the grant cycle and forces the FSM to IDLE with no evt_o. job_id_o is kept.
- Control addresses above 0xC alias modulo 16.
- Simultaneous events:
  - done_i and a stalled TRIGGER write in the same cycle: the write stays stalled that cycle and is granted the next cycle, when the FSM is IDLE.
  - SOFT_CLEAR and done_i in the same cycle: go to IDLE, evt_o=0.
- Reset mid-job: immediate return to IDLE. Any pending response is dropped (r_valid_o=0).

Test Plan:
- Reset, then write 0xDEADBEEF with be=0xF to register-file word 3, then read word 3 -> rf_we_o pulse at waddr 3; read response r_data_o=0xDEADBEEF one cycle after grant, with matching r_id_o.
- Write TRIGGER in IDLE -> start_o pulse, job_id_o 0->1, STATUS reads 0x1. Pulse done_i -> evt_o 1-cycle pulse, STATUS reads 0x0.
- While RUNNING, request a register-file write -> gnt_o=0 and rf_we_o=0 until done_i. The write is granted the cycle after done_i and the response follows one cycle later.
- While RUNNING, read register-file word 7 and the JOB_ID register -> both granted, correct data returned with 1-cycle latency.
- SOFT_CLEAR write while RUNNING -> rf_clear_o pulse, FSM goes to IDLE, no evt_o, job_id_o unchanged.
- Issue 2**IdWidth triggers -> job_id_o wraps from 0xFF to 0x00. Assert rst_i mid-job -> all outputs return to 0 immediately.
